// File: rtl/nes_dma_pkg.sv
// Shared NES DMA definitions: sequencer states, the $4014 trigger address and the
// default OAM transfer length. Also intended for the future DMC DMA engine.
package nes_dma_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HALT  = 3'd1,
    ALIGN = 3'd2,
    READ  = 3'd3,
    WRITE = 3'd4
  } dma_state_t;

  localparam logic [15:0] DMA_REG_ADDR = 16'h4014;
  localparam int          XFER_LEN_DEF = 256;

endpackage

// File: rtl/oam_dma_ctrl.sv
// Sprite OAM DMA sequencer: a CPU write of page PP to $4014 halts the CPU and copies
// XFER_LEN bytes from RAM $PP00.. into PPU OAM. Define OAM_DMA_ODD_ALIGN_EN for the
// NES-accurate extra alignment cycle when the transfer starts on an odd CPU cycle.
module oam_dma_ctrl
  import nes_dma_pkg::*;
#(
  parameter int                ADDR_W   = 16,
  parameter int                DATA_W   = 8,
  parameter logic [ADDR_W-1:0] DMA_REG  = ADDR_W'(DMA_REG_ADDR),
  parameter int                XFER_LEN = XFER_LEN_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_ce,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              cpu_we,
  output logic              cpu_halt,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [7:0]        oam_addr,
  output logic [DATA_W-1:0] oam_wdata,
  output logic              oam_we,
  output logic              busy,
  output logic              done,
  output dma_state_t        dbg_state
);

  localparam int               IDX_W    = (XFER_LEN > 1) ? $clog2(XFER_LEN) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(XFER_LEN - 1);

  dma_state_t        r_state, w_state_nxt;
  logic [DATA_W-1:0] r_page, w_page_nxt;
  logic [IDX_W-1:0]  r_idx, w_idx_nxt;
  logic              w_trigger, w_write, w_last, w_busy;

  // Every strobe here (trigger, oam_we, done) is qualified by cpu_ce: it only counts
  // on a clk where cpu_ce=1, and no state moves on any other clk.
  assign w_trigger = cpu_ce & cpu_we & (cpu_addr == DMA_REG);

`ifdef OAM_DMA_ODD_ALIGN_EN
  logic r_parity;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       r_parity <= 1'b0;
    else if (cpu_ce) r_parity <= ~r_parity;
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_page  <= '0;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_page  <= w_page_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_page_nxt  = r_page;
    w_idx_nxt   = r_idx;
    w_write     = 1'b0;
    w_last      = 1'b0;
    if (cpu_ce) begin
      case (r_state)
        IDLE: begin
          if (w_trigger) begin
            w_state_nxt = HALT;
            w_page_nxt  = cpu_wdata;
            w_idx_nxt   = '0;
          end
        end
`ifdef OAM_DMA_ODD_ALIGN_EN
        // Parity has already toggled past the trigger cycle: 0 here means an odd start.
        HALT:  w_state_nxt = r_parity ? READ : ALIGN;
        ALIGN: w_state_nxt = READ;
`else
        HALT:  w_state_nxt = READ;
`endif
        READ:  w_state_nxt = WRITE;
        WRITE: begin
          w_write = 1'b1;
          if (r_idx == LAST_IDX) begin
            w_state_nxt = IDLE;
            w_last      = 1'b1;
          end else begin
            w_idx_nxt   = r_idx + 1'b1;
            w_state_nxt = READ;
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // The RAM address is held from HALT onwards, so read data is ready by WRITE.
  assign w_busy    = (r_state != IDLE);
  assign busy      = w_busy;
  assign cpu_halt  = w_busy;
  assign mem_addr  = w_busy ? ADDR_W'({r_page, 8'(r_idx)}) : '0;
  assign mem_we    = 1'b0;
  assign oam_we    = w_write;
  assign oam_addr  = w_write ? 8'(r_idx) : 8'd0;
  assign oam_wdata = w_write ? mem_rdata : '0;
  assign done      = w_last;
  assign dbg_state = r_state;

endmodule
